// File: rtl/centroid_tracker.sv
// centroid_tracker
// Accumulates the coordinates of marker-coloured pixels over a frame and, at
// frame end, divides the sums by the hit count to produce the blob centre.
// Two restoring dividers (X and Y) share the hit count as divisor and retire
// one quotient bit per clock. The next frame keeps accumulating meanwhile.
// The ready strobe is suppressed on the first good frame after losing track,
// so downstream gesture detectors never see a jump from a stale centre.

`timescale 1ns/1ps

module centroid_tracker #(
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_hit,
    input  logic       frame_end,
    output logic [9:0] X_center,
    output logic [9:0] Y_center,
    output logic       ready,
    output logic       track_valid
);

    localparam logic [1:0] ST_IDLE_ACC = 2'd0;
    localparam logic [1:0] ST_DIVIDE   = 2'd1;
    localparam logic [1:0] ST_UPDATE   = 2'd2;

    localparam logic [4:0]  DIV_STEPS = 5'd28;
    localparam logic [18:0] MIN_CNT   = 19'(MIN_PIXELS);

    logic [1:0]  state_q,      state_d;
    logic [27:0] sumX_q,       sumX_d;
    logic [27:0] sumY_q,       sumY_d;
    logic [18:0] cnt_q,        cnt_d;
    logic [18:0] divisor_q,    divisor_d;
    logic [27:0] quoX_q,       quoX_d;
    logic [27:0] quoY_q,       quoY_d;
    logic [19:0] remX_q,       remX_d;
    logic [19:0] remY_q,       remY_d;
    logic [4:0]  step_q,       step_d;
    logic [9:0]  xCenter_q,    xCenter_d;
    logic [9:0]  yCenter_q,    yCenter_d;
    logic        ready_q,      ready_d;
    logic        trackValid_q, trackValid_d;

    logic        hitNow;
    logic [27:0] hitX;
    logic [27:0] hitY;
    logic [27:0] snapX;
    logic [27:0] snapY;
    logic [18:0] snapCnt;
    logic        enoughHits;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, subtract the divisor if it fits, and shift the
    // resulting quotient bit into the low end of the dividend register.
    function automatic logic [47:0] divStep(
        input logic [19:0] rem,
        input logic [27:0] quo,
        input logic [18:0] dvs
    );
        logic [19:0] trial;
        trial = {rem[18:0], quo[27]};
        if (trial >= {1'b0, dvs}) begin
            divStep = {trial - {1'b0, dvs}, quo[26:0], 1'b1};
        end else begin
            divStep = {trial, quo[26:0], 1'b0};
        end
    endfunction

    // Frame totals including a hit that coincides with frame_end.
    always_comb begin
        hitNow     = pix_valid & pix_hit;
        hitX       = hitNow ? {18'd0, pix_x} : 28'd0;
        hitY       = hitNow ? {18'd0, pix_y} : 28'd0;
        snapX      = sumX_q + hitX;
        snapY      = sumY_q + hitY;
        snapCnt    = cnt_q + {18'd0, hitNow};
        enoughHits = (snapCnt >= MIN_CNT);
    end

    // Next-state logic: accumulation, frame-end snapshot, division, update.
    always_comb begin
        state_d      = state_q;
        sumX_d       = sumX_q;
        sumY_d       = sumY_q;
        cnt_d        = cnt_q;
        divisor_d    = divisor_q;
        quoX_d       = quoX_q;
        quoY_d       = quoY_q;
        remX_d       = remX_q;
        remY_d       = remY_q;
        step_d       = step_q;
        xCenter_d    = xCenter_q;
        yCenter_d    = yCenter_q;
        ready_d      = 1'b0;
        trackValid_d = trackValid_q;

        // Accumulators always restart at frame_end, even when that frame
        // is dropped because the divider is still busy.
        if (frame_end) begin
            sumX_d = 28'd0;
            sumY_d = 28'd0;
            cnt_d  = 19'd0;
        end else if (hitNow) begin
            sumX_d = snapX;
            sumY_d = snapY;
            cnt_d  = snapCnt;
        end

        case (state_q)
            ST_IDLE_ACC: begin
                if (frame_end) begin
                    divisor_d = snapCnt;
                    quoX_d    = snapX;
                    quoY_d    = snapY;
                    remX_d    = 20'd0;
                    remY_d    = 20'd0;
                    step_d    = 5'd0;
                    if (enoughHits) begin
                        state_d = ST_DIVIDE;
                    end else begin
                        trackValid_d = 1'b0;
                    end
                end
            end

            ST_DIVIDE: begin
                if (step_q != DIV_STEPS) begin
                    {remX_d, quoX_d} = divStep(remX_q, quoX_q, divisor_q);
                    {remY_d, quoY_d} = divStep(remY_q, quoY_q, divisor_q);
                    step_d           = step_q + 5'd1;
                end else begin
                    xCenter_d    = quoX_q[9:0];
                    yCenter_d    = quoY_q[9:0];
                    ready_d      = trackValid_q;
                    trackValid_d = 1'b1;
                    state_d      = ST_UPDATE;
                end
            end

            ST_UPDATE: begin
                state_d = ST_IDLE_ACC;
            end

            default: begin
                state_d = ST_IDLE_ACC;
            end
        endcase
    end

    // State registers; reset abandons any division in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE_ACC;
            sumX_q       <= 28'd0;
            sumY_q       <= 28'd0;
            cnt_q        <= 19'd0;
            divisor_q    <= 19'd0;
            quoX_q       <= 28'd0;
            quoY_q       <= 28'd0;
            remX_q       <= 20'd0;
            remY_q       <= 20'd0;
            step_q       <= 5'd0;
            xCenter_q    <= 10'd0;
            yCenter_q    <= 10'd0;
            ready_q      <= 1'b0;
            trackValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sumX_q       <= sumX_d;
            sumY_q       <= sumY_d;
            cnt_q        <= cnt_d;
            divisor_q    <= divisor_d;
            quoX_q       <= quoX_d;
            quoY_q       <= quoY_d;
            remX_q       <= remX_d;
            remY_q       <= remY_d;
            step_q       <= step_d;
            xCenter_q    <= xCenter_d;
            yCenter_q    <= yCenter_d;
            ready_q      <= ready_d;
            trackValid_q <= trackValid_d;
        end
    end

    assign X_center    = xCenter_q;
    assign Y_center    = yCenter_q;
    assign ready       = ready_q;
    assign track_valid = trackValid_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Testbench for centroid_tracker: two instances (MIN_PIXELS 64 and 3) share
// one pixel stream; a frame-level reference model predicts every output each
// cycle, and directed scenarios add hand-computed expectations.

`timescale 1ns/1ps

module tb_centroid_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_hit = 1'b0;
    logic       frame_end = 1'b0;
    logic [9:0] pix_x = 10'd0;
    logic [9:0] pix_y = 10'd0;

    logic [9:0] xA, yA, xB, yB;
    logic       readyA, readyB, tvA, tvB;

    int checks = 0;
    int errors = 0;
    bit compareOn = 1'b0;

    centroid_tracker #(.MIN_PIXELS(64)) dutA (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_hit(pix_hit), .frame_end(frame_end),
        .X_center(xA), .Y_center(yA), .ready(readyA), .track_valid(tvA)
    );

    centroid_tracker #(.MIN_PIXELS(3)) dutB (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_hit(pix_hit), .frame_end(frame_end),
        .X_center(xB), .Y_center(yB), .ready(readyB), .track_valid(tvB)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Compare one value and report any difference
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; returns 2 ns after the edge that sampled them
    task automatic applyStimulus(input logic v, input logic h, input logic [9:0] x,
                                 input logic [9:0] y, input logic fe);
        pix_valid = v;
        pix_hit   = h;
        pix_x     = x;
        pix_y     = y;
        frame_end = fe;
        @(posedge clk);
        #2;
    endtask

    // Rectangle of hits followed by frame_end (or frame_end on the last hit)
    task automatic sendFrame(input int x0, input int y0, input int w, input int h,
                             input bit feWithLast);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                applyStimulus(1'b1, 1'b1, 10'(x0 + c), 10'(y0 + r),
                              feWithLast && (r == h - 1) && (c == w - 1));
            end
        end
        if (!feWithLast) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
    endtask

    // Idle cycles after frame_end, noting where each instance's ready appears
    task automatic waitReady(input int maxCycles, output int firstA, output int highA,
                             output int firstB);
        firstA = 0;
        highA  = 0;
        firstB = 0;
        for (int k = 1; k <= maxCycles; k++) begin
            applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
            if (readyA) begin
                if (firstA == 0) firstA = k;
                highA++;
            end
            if (readyB && firstB == 0) firstB = k;
        end
    endtask

    // Reference model: frame sums, integer division, and the frame-level
    // timing rules (result 29 edges after frame_end, 30-edge busy window)
    longint   accX[2], accY[2], accN[2], pendX[2], pendY[2];
    longint   fireEdge[2], busyUntil[2];
    longint   minPix[2] = '{64, 3};
    longint   edgeNo;
    longint   nTmp, sxTmp, syTmp;
    bit       pending[2];
    logic [9:0] mX[2], mY[2];
    logic     mReady[2], mTv[2];
    bit       hitNow;

    // Model update on each sampling edge, cleared by reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edgeNo = 0;
            for (int i = 0; i < 2; i++) begin
                accX[i] = 0; accY[i] = 0; accN[i] = 0;
                pendX[i] = 0; pendY[i] = 0; fireEdge[i] = 0;
                busyUntil[i] = -1; pending[i] = 1'b0;
                mX[i] = 10'd0; mY[i] = 10'd0; mReady[i] = 1'b0; mTv[i] = 1'b0;
            end
        end else begin
            edgeNo++;
            hitNow = pix_valid && pix_hit;
            for (int i = 0; i < 2; i++) begin
                mReady[i] = 1'b0;
                if (pending[i] && edgeNo == fireEdge[i]) begin
                    mReady[i]  = mTv[i];
                    mX[i]      = 10'(pendX[i]);
                    mY[i]      = 10'(pendY[i]);
                    mTv[i]     = 1'b1;
                    pending[i] = 1'b0;
                end
                if (frame_end) begin
                    nTmp  = accN[i] + (hitNow ? 1 : 0);
                    sxTmp = accX[i] + (hitNow ? longint'(pix_x) : 0);
                    syTmp = accY[i] + (hitNow ? longint'(pix_y) : 0);
                    if (edgeNo > busyUntil[i]) begin
                        if (nTmp < minPix[i]) begin
                            mTv[i] = 1'b0;
                        end else begin
                            pending[i]   = 1'b1;
                            fireEdge[i]  = edgeNo + 29;
                            busyUntil[i] = edgeNo + 30;
                            pendX[i]     = sxTmp / nTmp;
                            pendY[i]     = syTmp / nTmp;
                        end
                    end
                    accX[i] = 0; accY[i] = 0; accN[i] = 0;
                end else if (hitNow) begin
                    accX[i] += longint'(pix_x);
                    accY[i] += longint'(pix_y);
                    accN[i] += 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("A.X_center",    32'(xA),     32'(mX[0]));
            checkOutput("A.Y_center",    32'(yA),     32'(mY[0]));
            checkOutput("A.ready",       32'(readyA), 32'(mReady[0]));
            checkOutput("A.track_valid", 32'(tvA),    32'(mTv[0]));
            checkOutput("B.X_center",    32'(xB),     32'(mX[1]));
            checkOutput("B.Y_center",    32'(yB),     32'(mY[1]));
            checkOutput("B.ready",       32'(readyB), 32'(mReady[1]));
            checkOutput("B.track_valid", 32'(tvB),    32'(mTv[1]));
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    int firstA, highA, firstB;

    // Directed scenarios
    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        compareOn = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        checkOutput("reset.X", 32'(xA), 32'd0);
        checkOutput("reset.Y", 32'(yA), 32'd0);
        checkOutput("reset.ready", 32'(readyA), 32'd0);
        checkOutput("reset.track_valid", 32'(tvA), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);

        // Single blob, first frame: silent reload
        $display("[TB] single blob");
        sendFrame(300, 200, 10, 10, 1'b0);
        waitReady(35, firstA, highA, firstB);
        checkOutput("blob1.no_ready", 32'(highA), 32'd0);
        checkOutput("blob1.X", 32'(xA), 32'd304);
        checkOutput("blob1.Y", 32'(yA), 32'd204);
        checkOutput("blob1.track_valid", 32'(tvA), 32'd1);

        // Second frame: one ready pulse 29 cycles after frame_end
        sendFrame(300, 200, 10, 10, 1'b0);
        waitReady(35, firstA, highA, firstB);
        checkOutput("blob2.ready_latency", 32'(firstA), 32'd29);
        checkOutput("blob2.ready_width", 32'(highA), 32'd1);
        checkOutput("blob2.X", 32'(xA), 32'd304);
        checkOutput("blob2.Y", 32'(yA), 32'd204);

        // Reset in the middle of a division
        $display("[TB] reset mid-divide");
        sendFrame(300, 200, 10, 10, 1'b0);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("midreset.X", 32'(xA), 32'd0);
        checkOutput("midreset.Y", 32'(yA), 32'd0);
        checkOutput("midreset.ready", 32'(readyA), 32'd0);
        checkOutput("midreset.track_valid", 32'(tvA), 32'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        sendFrame(300, 200, 10, 10, 1'b0);
        waitReady(35, firstA, highA, firstB);
        checkOutput("postreset1.no_ready", 32'(highA), 32'd0);
        checkOutput("postreset1.X", 32'(xA), 32'd304);
        sendFrame(300, 200, 10, 10, 1'b0);
        waitReady(35, firstA, highA, firstB);
        checkOutput("postreset2.ready_latency", 32'(firstA), 32'd29);

        // Truncation: three hits, MIN_PIXELS 3 accepts, 64 rejects
        $display("[TB] truncation");
        applyStimulus(1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'd1, 10'd1, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'd1, 10'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        waitReady(35, firstA, highA, firstB);
        checkOutput("trunc3.B_ready_latency", 32'(firstB), 32'd29);
        checkOutput("trunc3.B_X", 32'(xB), 32'd0);
        checkOutput("trunc3.B_Y", 32'(yB), 32'd0);
        checkOutput("trunc3.B_track_valid", 32'(tvB), 32'd1);
        checkOutput("trunc3.A_track_valid", 32'(tvA), 32'd0);
        checkOutput("trunc3.A_X_held", 32'(xA), 32'd304);
        checkOutput("trunc3.A_no_ready", 32'(highA), 32'd0);

        // Two hits: below MIN_PIXELS 3 as well
        applyStimulus(1'b1, 1'b1, 10'd5, 10'd5, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'd6, 10'd6, 1'b0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        waitReady(35, firstA, highA, firstB);
        checkOutput("trunc2.B_track_valid", 32'(tvB), 32'd0);
        checkOutput("trunc2.B_no_ready", 32'(firstB), 32'd0);
        checkOutput("trunc2.B_X_held", 32'(xB), 32'd0);

        // 63 hits plus one on the frame_end cycle
        $display("[TB] boundary hit on frame_end");
        sendFrame(100, 50, 8, 8, 1'b1);
        waitReady(35, firstA, highA, firstB);
        checkOutput("boundary.track_valid", 32'(tvA), 32'd1);
        checkOutput("boundary.no_ready", 32'(highA), 32'd0);
        checkOutput("boundary.X", 32'(xA), 32'd103);
        checkOutput("boundary.Y", 32'(yA), 32'd53);
        sendFrame(100, 50, 8, 8, 1'b0);
        waitReady(35, firstA, highA, firstB);
        checkOutput("boundary_next.ready_latency", 32'(firstA), 32'd29);
        checkOutput("boundary_next.X", 32'(xA), 32'd103);
        checkOutput("boundary_next.Y", 32'(yA), 32'd53);

        // Second frame_end 10 cycles after the first is dropped; hits in
        // between are discarded with it
        $display("[TB] early frame_end");
        sendFrame(300, 200, 10, 10, 1'b0);
        firstA = 0;
        highA  = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus((k >= 2 && k <= 6), (k >= 2 && k <= 6), 10'd600, 10'd400, (k == 10));
            if (readyA) begin
                if (firstA == 0) firstA = k;
                highA++;
            end
        end
        checkOutput("early.ready_latency", 32'(firstA), 32'd29);
        checkOutput("early.ready_width", 32'(highA), 32'd1);
        checkOutput("early.X", 32'(xA), 32'd304);
        checkOutput("early.Y", 32'(yA), 32'd204);
        sendFrame(100, 50, 8, 8, 1'b0);
        waitReady(35, firstA, highA, firstB);
        checkOutput("early_next.X", 32'(xA), 32'd103);
        checkOutput("early_next.Y", 32'(yA), 32'd53);

        // Bottom 60 rows fully hit: large dividends
        $display("[TB] large frame");
        sendFrame(0, 420, 640, 60, 1'b0);
        waitReady(35, firstA, highA, firstB);
        checkOutput("large.ready_latency", 32'(firstA), 32'd29);
        checkOutput("large.X", 32'(xA), 32'd319);
        checkOutput("large.Y", 32'(yA), 32'd449);

        compareOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/centroid_tracker.md
# centroid_tracker

Computes the per-frame centroid of marker-coloured pixels from the camera pixel stream and presents it as `X_center`/`Y_center` with a one-cycle `ready` strobe. It sits directly upstream of the gesture detectors (down/up/left/right action blocks). Those blocks compare each new centre against a centre delayed a few clocks, and they count their cooldown in `ready` pulses, i.e. frames.

## Interface
Parameters:
- `MIN_PIXELS`, default 64: minimum hit count for a frame to be tracked. Legal range is 1..307200.

Ports:
- `clk` input 1: pixel/system clock.
- `rst` input 1: asynchronous, active-low reset.
- `pix_valid` input 1: current pixel coordinates are valid (active video).
- `pix_x` input 10: pixel column, 0..639.
- `pix_y` input 10: pixel row, 0..479.
- `pix_hit` input 1: pixel matches the marker colour. Ignored unless `pix_valid` is high.
- `frame_end` input 1: one-cycle pulse after the last pixel of a frame.
- `X_center` output 10: registered mean column of hits.
- `Y_center` output 10: registered mean row of hits.
- `ready` output 1: one-cycle strobe. New `X_center`/`Y_center` values are valid in this same cycle.
- `track_valid` output 1: level. High while the most recent completed frame met `MIN_PIXELS`.

## Operation
- Accumulators:
  - `sum_x` is 28 bits, `sum_y` is 28 bits, `cnt` is 19 bits.
  - On every cycle with `pix_valid && pix_hit`: `sum_x += pix_x`, `sum_y += pix_y`, `cnt += 1`.
  - Overflow is impossible for a 640x480 frame. No saturation logic.
- States: IDLE_ACC, DIVIDE, UPDATE.
- IDLE_ACC, on `frame_end`:
  - Snapshot `sum_x`, `sum_y`, `cnt` into the divider operand registers.
  - Clear the accumulators in the same cycle.
  - A hit on the same cycle as `frame_end` belongs to the closing frame: it is included in the snapshot, and the accumulators restart at 0.
  - If the snapshot count is below `MIN_PIXELS`: stay in IDLE_ACC, clear `track_valid`, do not pulse `ready`, hold the centres.
  - Otherwise go to DIVIDE.
- DIVIDE:
  - Two parallel restoring dividers (X and Y) share the divisor `cnt`.
  - One quotient bit per cycle, MSB first, 28 iterations.
  - The quotient is floor(sum/cnt), always ≤ 639 (x) or ≤ 479 (y). Take the low 10 bits.
  - Accumulation of the next frame continues during DIVIDE.
- UPDATE (one cycle):
  - Load `X_center`/`Y_center` from the quotients.
  - Assert `ready` only if `track_valid` was already 1. This prevents a fake jump from a stale or reset centre on reacquisition; the first good frame only reloads the centres.
  - Then set `track_valid` = 1 and return to IDLE_ACC.
- `frame_end` while in DIVIDE or UPDATE:
  - The frame is dropped: no division for it, and `track_valid` is unchanged.
  - The accumulators are still cleared so the next frame starts clean.
- Reset, asynchronous, at any time:
  - State → IDLE_ACC.
  - Accumulators and divider registers → 0.
  - `X_center` = 0, `Y_center` = 0, `ready` = 0, `track_valid` = 0.
  - An in-flight division is abandoned.

## Timing
- Take the edge sampling `frame_end` as edge 0.
  - The snapshot is taken at edge 0.
  - DIVIDE occupies edges 1..28.
  - UPDATE is the cycle after edge 29: centres and `ready` are valid from edge 29 to edge 30.
  - `ready` is low again after edge 30.
- End-to-end latency is 29 cycles from `frame_end` to `ready`. The busy window is 30 cycles.
- `ready` is never high on two consecutive cycles. Consecutive pulses are at least 30 cycles apart.
- Centres change only on edges where `ready` rises, or on the silent first-reacquisition update. They are stable at all other times.
- `track_valid` changes:
  - at edge 0, for a low-count frame;
  - at edge 29, for a good frame.

## Test plan
- **Reset:** hold `rst` = 0 mid-DIVIDE → all outputs 0 immediately. After release, no `ready` until two good frames.
- **Single blob:** 100 hits at x = 300..309, y = 200..209, two consecutive frames:
  - first frame → centres 304/204, `track_valid` = 1, no `ready`;
  - second frame → `ready` for exactly one cycle, 29 cycles after `frame_end`, centres 304/204.
- **Truncation:** hits at (0,0), (1,1), (1,0) → quotients floor(2/3) = 0 and floor(1/3) = 0.
  - With `MIN_PIXELS` = 3: accepted, centres 0/0.
  - With 2 hits and `MIN_PIXELS` = 3: `track_valid` drops, centres held, no `ready`.
- **Boundary hit on `frame_end`:** 63 hits plus one hit coincident with `frame_end` → count 64, frame accepted. The next frame's accumulators start at 0.
- **Early `frame_end`:** a second `frame_end` 10 cycles after the first → it is dropped, `ready` still fires at +29 with the first frame's result, and the accumulators are cleared.
- **Full frame:** every pixel hit (307200) → centres 319/239. No overflow and no wrong quotient bits.
